// File: rtl/onoff_pkg.sv
// Shared types and defaults for the push-button power on/off controller.
package onoff_pkg;

  // Encoding picked so onoff is bit 0 and busy is bit 1 of the state register.
  typedef enum logic [1:0] {
    ST_OFF       = 2'b00,
    ST_ON        = 2'b01,
    ST_DOWN_WAIT = 2'b10,
    ST_UP_WAIT   = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    FC_NONE    = 2'b00,
    FC_EXT     = 2'b01,
    FC_TIMEOUT = 2'b10
  } fault_cause_e;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
  localparam int unsigned DEF_TIMEOUT_CYCLES  = 32;
  localparam int unsigned DEF_SETTLE_CYCLES   = 12;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // The first recorded cause is kept until explicitly acknowledged.
  function automatic fault_cause_e latch_cause(input fault_cause_e cur,
                                               input fault_cause_e cause);
    return (cur == FC_NONE) ? cause : cur;
  endfunction

endpackage

// File: rtl/onoff_if.sv
// Handshake between the on/off controller and its environment.
interface onoff_if;
  import onoff_pkg::*;

  logic         key_n;
  logic         fault;
  logic         ready;
  logic         onoff;
  logic         busy;
  fault_cause_e fault_cause;

  modport master (
    output key_n,
    output fault,
    output ready,
    input  onoff,
    input  busy,
    input  fault_cause
  );

  modport slave (
    input  key_n,
    input  fault,
    input  ready,
    output onoff,
    output busy,
    output fault_cause
  );

endinterface

// File: rtl/onoff_key_debounce.sv
// Two-flop synchronizer plus debouncer for the active-low push-button;
// emits a one-cycle registered pulse when the accepted level falls.
module key_debounce
  import onoff_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic press
);

  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             level_q;
  logic [CNT_W-1:0] cnt_q;

  // Reset to the released level so leaving reset never produces a pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= 2'b11;
      level_q <= 1'b1;
      cnt_q   <= '0;
      press   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], key_n};
      press  <= 1'b0;
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        level_q <= sync_q[1];
        cnt_q   <= '0;
        press   <= ~sync_q[1];
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/onoff_controller.sv
// Push-button power request controller: debounced key, ready handshake
// with timeout, settle time after power-down and sticky fault reporting.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_OFF       | power off; press powers up, or acknowledges a stored fault
// ST_UP_WAIT   | onoff asserted, waiting for ready (bounded by timeout)
// ST_ON        | powered; press, fault or lost ready powers down
// ST_DOWN_WAIT | onoff released, waiting for ready low and settle time
module onoff_controller
  import onoff_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
  parameter int unsigned SETTLE_CYCLES   = DEF_SETTLE_CYCLES
) (
  input logic    clk,
  input logic    reset,
  onoff_if.slave bus
);

  localparam int unsigned WAIT_MAX = max_u(TIMEOUT_CYCLES, SETTLE_CYCLES);
  localparam int unsigned WAIT_W   = $clog2(WAIT_MAX + 1);

  logic              press;
  state_e            state_q, state_d;
  fault_cause_e      fc_q, fc_d;
  logic [WAIT_W-1:0] wait_q;
  logic              timeout_hit;
  logic              settle_done;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .clk   (clk),
    .reset (reset),
    .key_n (bus.key_n),
    .press (press)
  );

  // wait_q counts edges since state entry, so the decision on the Nth edge
  // after entry sees N-1 here.
  assign timeout_hit = (wait_q >= WAIT_W'(TIMEOUT_CYCLES - 1));
  assign settle_done = (wait_q >= WAIT_W'(SETTLE_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_OFF;
      fc_q    <= FC_NONE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      fc_q    <= fc_d;
      if (state_d != state_q) begin
        wait_q <= '0;
      end else if (wait_q != WAIT_W'(WAIT_MAX)) begin
        wait_q <= wait_q + WAIT_W'(1);
      end
    end
  end

  // Fault always outranks a press arriving in the same cycle.
  always_comb begin
    state_d = state_q;
    fc_d    = fc_q;
    case (state_q)
      ST_OFF: begin
        if (press && !bus.fault) begin
          if (fc_q != FC_NONE) begin
            fc_d = FC_NONE;
          end else begin
            state_d = ST_UP_WAIT;
          end
        end
      end
      ST_UP_WAIT: begin
        if (bus.fault) begin
          state_d = ST_DOWN_WAIT;
          fc_d    = latch_cause(fc_q, FC_EXT);
        end else if (bus.ready) begin
          state_d = ST_ON;
        end else if (timeout_hit) begin
          state_d = ST_DOWN_WAIT;
          fc_d    = latch_cause(fc_q, FC_TIMEOUT);
        end
      end
      ST_ON: begin
        if (bus.fault) begin
          state_d = ST_DOWN_WAIT;
          fc_d    = latch_cause(fc_q, FC_EXT);
        end else if (!bus.ready) begin
          state_d = ST_DOWN_WAIT;
          fc_d    = latch_cause(fc_q, FC_TIMEOUT);
        end else if (press) begin
          state_d = ST_DOWN_WAIT;
        end
      end
      ST_DOWN_WAIT: begin
        if (!bus.ready && settle_done) begin
          state_d = ST_OFF;
        end
      end
      default: begin
        state_d = ST_OFF;
      end
    endcase
  end

  always_comb begin
    bus.onoff       = (state_q == ST_UP_WAIT) || (state_q == ST_ON);
    bus.busy        = (state_q == ST_UP_WAIT) || (state_q == ST_DOWN_WAIT);
    bus.fault_cause = fc_q;
  end

endmodule

// File: tb/tb_onoff_controller.sv
// Directed bench for onoff_controller with a cycle-level behavioural model.
module tb_onoff_controller;
  import onoff_pkg::*;

  localparam int DB = 4;
  localparam int TO = 32;
  localparam int ST = 12;

  logic        clk = 1'b0;
  logic        reset;
  int          rdy_mode = 0;        // 0: ready low, 1: ready high, 2: onoff delayed 11
  logic [10:0] sr = '0;
  bit          chk_en = 1'b0;
  int          n_checks = 0;
  int          n_err = 0;

  onoff_if bus();

  onoff_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Downstream sequencer stand-in.
  always @(posedge clk) sr <= {sr[9:0], bus.onoff};
  assign bus.ready = (rdy_mode == 2) ? sr[10] : (rdy_mode == 1);

  // Model: phase 0 off, 1 powering up, 2 on, 3 powering down.
  int         m_phase = 0;
  int         m_cycles = 0;
  int         m_streak = 0;
  bit         m_level = 1'b1;
  bit         m_press = 1'b0;
  bit         m_k1 = 1'b1;
  bit         m_k2 = 1'b1;
  logic [1:0] m_fc = 2'd0;

  always @(posedge clk) begin
    bit pr;
    int nxt;
    bit synced;
    if (reset) begin
      m_phase = 0; m_cycles = 0; m_streak = 0;
      m_level = 1'b1; m_press = 1'b0; m_k1 = 1'b1; m_k2 = 1'b1; m_fc = 2'd0;
    end else begin
      pr  = m_press;
      nxt = m_phase;
      m_cycles++;
      case (m_phase)
        0: if (pr && !bus.fault) begin
             if (m_fc != 2'd0) m_fc = 2'd0;
             else nxt = 1;
           end
        1: if (bus.fault) begin
             nxt = 3; if (m_fc == 2'd0) m_fc = 2'd1;
           end else if (bus.ready) begin
             nxt = 2;
           end else if (m_cycles >= TO) begin
             nxt = 3; if (m_fc == 2'd0) m_fc = 2'd2;
           end
        2: if (bus.fault) begin
             nxt = 3; if (m_fc == 2'd0) m_fc = 2'd1;
           end else if (!bus.ready) begin
             nxt = 3; if (m_fc == 2'd0) m_fc = 2'd2;
           end else if (pr) begin
             nxt = 3;
           end
        3: if (!bus.ready && m_cycles >= ST) nxt = 0;
        default: nxt = 0;
      endcase
      if (nxt != m_phase) begin
        m_phase  = nxt;
        m_cycles = 0;
      end
      synced  = m_k2;
      m_press = 1'b0;
      if (synced != m_level) begin
        m_streak++;
        if (m_streak == DB) begin
          m_level  = synced;
          m_streak = 0;
          m_press  = !synced;
        end
      end else begin
        m_streak = 0;
      end
      m_k2 = m_k1;
      m_k1 = bus.key_n;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_onoff", 32'(bus.onoff), 32'(m_phase == 1 || m_phase == 2));
      chk("model_busy", 32'(bus.busy), 32'(m_phase == 1 || m_phase == 3));
      chk("model_fault_cause", 32'(bus.fault_cause), 32'(m_fc));
    end
  end

  task automatic press_key(input int n);
    bus.key_n = 1'b0;
    repeat (n) @(negedge clk);
    bus.key_n = 1'b1;
  endtask

  initial begin
    reset     = 1'b1;
    bus.key_n = 1'b1;
    bus.fault = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_onoff", 32'(bus.onoff), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_fault_cause", 32'(bus.fault_cause), 0);

    // Power-up with ready following onoff by 11 cycles.
    reset = 1'b0; bus.key_n = 1'b0; rdy_mode = 2;
    repeat (6) @(negedge clk);
    chk("pu_onoff_edge6", 32'(bus.onoff), 0);
    @(negedge clk);
    chk("pu_onoff_edge7", 32'(bus.onoff), 1);
    chk("pu_busy_edge7", 32'(bus.busy), 1);
    repeat (3) @(negedge clk);
    bus.key_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("pu_busy_edge18", 32'(bus.busy), 1);
    @(negedge clk);
    chk("pu_busy_edge19", 32'(bus.busy), 0);
    chk("pu_onoff_edge19", 32'(bus.onoff), 1);
    chk("pu_model_on", 32'(m_phase), 2);

    // Press while powering down is ignored.
    rdy_mode = 1;
    repeat (4) @(negedge clk);
    press_key(8);
    chk("pd_onoff", 32'(bus.onoff), 0);
    chk("pd_busy", 32'(bus.busy), 1);
    repeat (8) @(negedge clk);
    press_key(8);
    repeat (4) @(negedge clk);
    chk("pd_press_ignored_busy", 32'(bus.busy), 1);
    chk("pd_press_ignored_onoff", 32'(bus.onoff), 0);
    rdy_mode = 0;
    @(negedge clk);
    chk("pd_off_busy", 32'(bus.busy), 0);
    repeat (10) @(negedge clk);
    chk("pd_not_queued_onoff", 32'(bus.onoff), 0);

    // Ready timeout.
    press_key(8);
    repeat (30) @(negedge clk);
    chk("to_up_onoff_38", 32'(bus.onoff), 1);
    chk("to_up_busy_38", 32'(bus.busy), 1);
    @(negedge clk);
    chk("to_down_onoff_39", 32'(bus.onoff), 0);
    chk("to_down_busy_39", 32'(bus.busy), 1);
    chk("to_fault_cause", 32'(bus.fault_cause), 2);
    repeat (11) @(negedge clk);
    chk("to_settle_busy_50", 32'(bus.busy), 1);
    @(negedge clk);
    chk("to_settle_busy_51", 32'(bus.busy), 0);
    chk("to_fault_sticky", 32'(bus.fault_cause), 2);
    repeat (4) @(negedge clk);
    press_key(8);
    chk("to_ack_fault_cause", 32'(bus.fault_cause), 0);
    chk("to_ack_onoff", 32'(bus.onoff), 0);

    // Fault and press in the same cycle while on.
    repeat (10) @(negedge clk);
    rdy_mode = 2;
    press_key(8);
    repeat (14) @(negedge clk);
    chk("fp_on_onoff", 32'(bus.onoff), 1);
    chk("fp_on_busy", 32'(bus.busy), 0);
    bus.key_n = 1'b0;
    repeat (6) @(negedge clk);
    bus.fault = 1'b1;
    @(negedge clk);
    bus.fault = 1'b0;
    bus.key_n = 1'b1;
    chk("fp_down_onoff", 32'(bus.onoff), 0);
    chk("fp_down_busy", 32'(bus.busy), 1);
    chk("fp_fault_cause", 32'(bus.fault_cause), 1);
    repeat (25) @(negedge clk);
    chk("fp_off_busy", 32'(bus.busy), 0);
    chk("fp_fault_kept", 32'(bus.fault_cause), 1);
    press_key(8);
    chk("fp_ack_fault_cause", 32'(bus.fault_cause), 0);
    chk("fp_ack_onoff", 32'(bus.onoff), 0);

    // Short glitch must not be accepted.
    repeat (10) @(negedge clk);
    bus.key_n = 1'b0;
    repeat (3) @(negedge clk);
    bus.key_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("gl_onoff", 32'(bus.onoff), 0);
    chk("gl_busy", 32'(bus.busy), 0);

    // One-cycle reset during power-up.
    rdy_mode = 0;
    press_key(8);
    repeat (2) @(negedge clk);
    chk("mr_up_onoff", 32'(bus.onoff), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("mr_rst_onoff", 32'(bus.onoff), 0);
    chk("mr_rst_busy", 32'(bus.busy), 0);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    chk("mr_after_onoff", 32'(bus.onoff), 0);
    chk("mr_after_busy", 32'(bus.busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
